// File: rtl/gpio_irq_ctrl.sv
// GPIO interrupt aggregator: sticky per-pin pending/overflow latches feeding a
// fixed-priority (lowest index wins) arbiter with a req/ack handshake to the CPU.

module gpio_irq_pin (
  input  logic clk,
  input  logic reset,
  input  logic int_i,
  input  logic chg_i,
  input  logic ack_clr_i,
  input  logic bulk_clr_i,
  output logic pend_int_o,
  output logic pend_chg_o,
  output logic ovf_o
);
  logic pend_int_q, pend_int_d;
  logic pend_chg_q, pend_chg_d;
  logic ovf_q, ovf_d;
  logic clr;

  // A new pulse always wins over a clear in the same cycle. Overflow counts
  // only pulses landing on a bit that will still be pending afterwards.
  always_comb begin
    clr        = ack_clr_i | bulk_clr_i;
    pend_int_d = int_i | (pend_int_q & ~clr);
    pend_chg_d = chg_i | (pend_chg_q & ~clr);
    ovf_d      = (ovf_q & ~bulk_clr_i) |
                 (((int_i & pend_int_q) | (chg_i & pend_chg_q)) & ~clr);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_int_q <= 1'b0;
      pend_chg_q <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      pend_int_q <= pend_int_d;
      pend_chg_q <= pend_chg_d;
      ovf_q      <= ovf_d;
    end
  end

  assign pend_int_o = pend_int_q;
  assign pend_chg_o = pend_chg_q;
  assign ovf_o      = ovf_q;
endmodule

module gpio_irq_ctrl #(
  parameter int N_PINS = 8,
  parameter int ID_W   = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_PINS-1:0] irq_int_in,
  input  logic [N_PINS-1:0] irq_chg_in,
  input  logic              glb_en,
  input  logic              irq_ack,
  input  logic              clr_valid,
  input  logic [N_PINS-1:0] clr_mask,
  output logic              irq_req,
  output logic [ID_W-1:0]   irq_id,
  output logic [1:0]        irq_cause,
  output logic [N_PINS-1:0] pending,
  output logic [N_PINS-1:0] overflow
);
  typedef enum logic [1:0] {IDLE, ARB, REQ} state_e;

  state_e            state_q, state_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [1:0]        cause_q, cause_d;

  logic [N_PINS-1:0] pend_int, pend_chg;
  logic [N_PINS-1:0] sel, ack_clr, bulk_clr;
  logic              ack_fire, sel_bulk;
  logic [ID_W-1:0]   arb_id;
  logic [1:0]        arb_cause;

  assign ack_fire = (state_q == REQ) & irq_ack;
  assign bulk_clr = {N_PINS{clr_valid}} & clr_mask;
  assign ack_clr  = sel & {N_PINS{ack_fire}};
  assign sel_bulk = |(sel & bulk_clr);

  for (genvar g = 0; g < N_PINS; g++) begin : g_pin
    assign sel[g] = (id_q == ID_W'(g));

    gpio_irq_pin u_pin (
      .clk        (clk),
      .reset      (reset),
      .int_i      (irq_int_in[g]),
      .chg_i      (irq_chg_in[g]),
      .ack_clr_i  (ack_clr[g]),
      .bulk_clr_i (bulk_clr[g]),
      .pend_int_o (pend_int[g]),
      .pend_chg_o (pend_chg[g]),
      .ovf_o      (overflow[g])
    );
  end

  assign pending = pend_int | pend_chg;

  // Descending scan so the lowest pending index is the last one to assign.
  always_comb begin
    arb_id    = '0;
    arb_cause = '0;
    for (int i = N_PINS - 1; i >= 0; i--) begin
      if (pending[i]) begin
        arb_id    = ID_W'(i);
        arb_cause = {pend_chg[i], pend_int[i]};
      end
    end
  end

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    cause_d = cause_q;
    case (state_q)
      IDLE: if (glb_en && |pending) state_d = ARB;
      ARB: begin
        if (|pending) begin
          id_d    = arb_id;
          cause_d = arb_cause;
          state_d = REQ;
        end else begin
          state_d = IDLE;
        end
      end
      // Ack takes precedence over abort; both return to IDLE anyway, but only
      // ack drives the pin clear through ack_clr.
      REQ: if (irq_ack || !glb_en || sel_bulk) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      id_q    <= '0;
      cause_q <= '0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      cause_q <= cause_d;
    end
  end

  assign irq_req   = (state_q == REQ);
  assign irq_id    = id_q;
  assign irq_cause = cause_q;
endmodule

// File: tb/tb_gpio_irq_ctrl.sv
// Bench for gpio_irq_ctrl: directed scenarios plus randomized traffic checked
// against a cycle model built from the pending/arbitration rules.

module tb_gpio_irq_ctrl;
  localparam int N  = 8;
  localparam int IW = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  irq_int_in, irq_chg_in, clr_mask;
  logic          glb_en, irq_ack, clr_valid;
  logic          irq_req;
  logic [IW-1:0] irq_id;
  logic [1:0]    irq_cause;
  logic [N-1:0]  pending, overflow;

  int checks = 0;
  int failures = 0;

  // Reference model state
  logic [N-1:0]  m_pint, m_pchg, m_ovf;
  int            m_phase;  // 0 idle, 1 arbitrating, 2 requesting
  logic [IW-1:0] m_id;
  logic [1:0]    m_cause;

  gpio_irq_ctrl #(.N_PINS(N), .ID_W(IW)) dut (
    .clk(clk), .reset(reset), .irq_int_in(irq_int_in), .irq_chg_in(irq_chg_in),
    .glb_en(glb_en), .irq_ack(irq_ack), .clr_valid(clr_valid), .clr_mask(clr_mask),
    .irq_req(irq_req), .irq_id(irq_id), .irq_cause(irq_cause),
    .pending(pending), .overflow(overflow)
  );

  always #5 clk = ~clk;

  function automatic int lowest(input logic [N-1:0] v);
    logic [N-1:0] l;
    l = v & ((~v) + N'(1));
    return $clog2(l);
  endfunction

  task automatic model_reset();
    m_pint = '0; m_pchg = '0; m_ovf = '0;
    m_phase = 0; m_id = '0; m_cause = '0;
  endtask

  // Advance model with the inputs currently driven, clock the DUT, then drop strobes.
  task automatic tick();
    logic [N-1:0] bulk, clrv, pend;
    int nphase;
    bulk = clr_valid ? clr_mask : '0;
    clrv = bulk | (((m_phase == 2) && irq_ack) ? (N'(1) << m_id) : '0);
    pend = m_pint | m_pchg;
    nphase = m_phase;
    case (m_phase)
      0: if (glb_en && pend != 0) nphase = 1;
      1: if (pend == 0) nphase = 0;
         else begin
           m_id = IW'(lowest(pend));
           m_cause = {m_pchg[m_id], m_pint[m_id]};
           nphase = 2;
         end
      default: if (irq_ack || !glb_en || bulk[m_id]) nphase = 0;
    endcase
    m_ovf  = (m_ovf & ~bulk) | (((irq_int_in & m_pint) | (irq_chg_in & m_pchg)) & ~clrv);
    m_pint = irq_int_in | (m_pint & ~clrv);
    m_pchg = irq_chg_in | (m_pchg & ~clrv);
    m_phase = nphase;
    @(posedge clk); #1;
    irq_int_in = '0; irq_chg_in = '0; irq_ack = 1'b0; clr_valid = 1'b0; clr_mask = '0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    model_reset();
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    #2;
    checks++; if ({irq_req, irq_id, irq_cause, pending, overflow} !== '0) begin
      failures++; $display("FAIL reset_init got=%h exp=0", {irq_req, irq_id, irq_cause, pending, overflow}); end
    @(posedge clk); #1; reset = 1'b1;
    irq_int_in = '1; tick();
    irq_int_in = '1; tick();
    tick();
    checks++; if (irq_req !== 1'b1 || overflow !== 8'hFF) begin
      failures++; $display("FAIL reset_prereq got req=%b ovf=%h exp req=1 ovf=ff", irq_req, overflow); end
    #2 reset = 1'b0;
    #1;
    checks++; if (irq_req !== 1'b0 || pending !== '0 || overflow !== '0) begin
      failures++; $display("FAIL reset_async got req=%b pend=%h ovf=%h exp 0", irq_req, pending, overflow); end
    model_reset();
    @(posedge clk); #1; reset = 1'b1;
  endtask

  task automatic test_single();
    irq_int_in[5] = 1'b1; tick();
    checks++; if (pending !== 8'h20 || irq_req !== 1'b0) begin
      failures++; $display("FAIL single_pend got pend=%h req=%b exp 20/0", pending, irq_req); end
    tick();
    checks++; if (irq_req !== 1'b0) begin
      failures++; $display("FAIL single_early got=%b exp=0", irq_req); end
    tick();
    checks++; if ({irq_req, irq_id, irq_cause} !== {1'b1, 3'd5, 2'b01}) begin
      failures++; $display("FAIL single_req got req=%b id=%0d cause=%b exp 1/5/01", irq_req, irq_id, irq_cause); end
    tick(); tick();
    checks++; if ({irq_req, irq_id, irq_cause} !== {1'b1, 3'd5, 2'b01}) begin
      failures++; $display("FAIL single_hold got req=%b id=%0d cause=%b exp 1/5/01", irq_req, irq_id, irq_cause); end
    irq_ack = 1'b1; tick();
    checks++; if (irq_req !== 1'b0 || pending !== '0) begin
      failures++; $display("FAIL single_ack got req=%b pend=%h exp 0/00", irq_req, pending); end
  endtask

  task automatic test_priority();
    irq_chg_in[2] = 1'b1; irq_int_in[6] = 1'b1; tick(); tick(); tick();
    checks++; if ({irq_req, irq_id, irq_cause} !== {1'b1, 3'd2, 2'b10}) begin
      failures++; $display("FAIL prio_first got req=%b id=%0d cause=%b exp 1/2/10", irq_req, irq_id, irq_cause); end
    irq_ack = 1'b1; tick();
    checks++; if (irq_req !== 1'b0 || pending !== 8'h40) begin
      failures++; $display("FAIL prio_ack got req=%b pend=%h exp 0/40", irq_req, pending); end
    tick();
    checks++; if (irq_req !== 1'b0) begin
      failures++; $display("FAIL prio_gap got=%b exp=0", irq_req); end
    tick();
    checks++; if ({irq_req, irq_id, irq_cause} !== {1'b1, 3'd6, 2'b01}) begin
      failures++; $display("FAIL prio_second got req=%b id=%0d cause=%b exp 1/6/01", irq_req, irq_id, irq_cause); end
    irq_ack = 1'b1; tick();
  endtask

  task automatic test_overflow();
    irq_int_in[3] = 1'b1; tick();
    irq_int_in[3] = 1'b1; tick();
    checks++; if (overflow !== 8'h08) begin
      failures++; $display("FAIL ovf_set got=%h exp=08", overflow); end
    tick();
    checks++; if (irq_req !== 1'b1 || irq_id !== 3'd3) begin
      failures++; $display("FAIL ovf_req got req=%b id=%0d exp 1/3", irq_req, irq_id); end
    irq_ack = 1'b1; tick();
    checks++; if (overflow !== 8'h08 || pending !== '0) begin
      failures++; $display("FAIL ovf_after_ack got ovf=%h pend=%h exp 08/00", overflow, pending); end
    clr_valid = 1'b1; clr_mask = 8'h08; tick();
    checks++; if (overflow !== '0) begin
      failures++; $display("FAIL ovf_clear got=%h exp=00", overflow); end
  endtask

  task automatic test_glb_en();
    glb_en = 1'b0; irq_int_in[1] = 1'b1; tick();
    for (int k = 0; k < 4; k++) tick();
    checks++; if (pending !== 8'h02 || irq_req !== 1'b0) begin
      failures++; $display("FAIL glb_block got pend=%h req=%b exp 02/0", pending, irq_req); end
    glb_en = 1'b1; tick(); tick();
    checks++; if (irq_req !== 1'b1 || irq_id !== 3'd1) begin
      failures++; $display("FAIL glb_enable got req=%b id=%0d exp 1/1", irq_req, irq_id); end
    glb_en = 1'b0; tick();
    checks++; if (irq_req !== 1'b0 || pending !== 8'h02) begin
      failures++; $display("FAIL glb_drop got req=%b pend=%h exp 0/02", irq_req, pending); end
    glb_en = 1'b1; tick(); tick();
    checks++; if (irq_req !== 1'b1 || irq_id !== 3'd1) begin
      failures++; $display("FAIL glb_reissue got req=%b id=%0d exp 1/1", irq_req, irq_id); end
    irq_ack = 1'b1; tick();
  endtask

  task automatic test_ack_set();
    irq_int_in[4] = 1'b1; tick(); tick(); tick();
    checks++; if (irq_req !== 1'b1 || irq_id !== 3'd4) begin
      failures++; $display("FAIL ackset_req got req=%b id=%0d exp 1/4", irq_req, irq_id); end
    irq_ack = 1'b1; irq_int_in[4] = 1'b1; tick();
    checks++; if (irq_req !== 1'b0 || pending !== 8'h10 || overflow !== '0) begin
      failures++; $display("FAIL ackset_keep got req=%b pend=%h ovf=%h exp 0/10/00", irq_req, pending, overflow); end
    tick(); tick();
    checks++; if (irq_req !== 1'b1 || irq_id !== 3'd4) begin
      failures++; $display("FAIL ackset_reissue got req=%b id=%0d exp 1/4", irq_req, irq_id); end
    irq_ack = 1'b1; tick();
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      irq_int_in = N'($urandom & $urandom & $urandom);
      irq_chg_in = N'($urandom & $urandom & $urandom);
      glb_en     = ($urandom_range(0, 7) != 0);
      irq_ack    = ($urandom_range(0, 2) == 0);
      clr_valid  = ($urandom_range(0, 9) == 0);
      clr_mask   = N'($urandom);
      tick();
      checks++;
      if ({irq_req, irq_id, irq_cause, pending, overflow} !==
          {(m_phase == 2), m_id, m_cause, m_pint | m_pchg, m_ovf}) begin
        failures++;
        $display("FAIL rand_cycle%0d got req=%b id=%0d cause=%b pend=%h ovf=%h exp req=%b id=%0d cause=%b pend=%h ovf=%h",
                 c, irq_req, irq_id, irq_cause, pending, overflow,
                 (m_phase == 2), m_id, m_cause, m_pint | m_pchg, m_ovf);
      end
    end
    glb_en = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    irq_int_in = '0; irq_chg_in = '0; clr_mask = '0;
    glb_en = 1'b1; irq_ack = 1'b0; clr_valid = 1'b0;
    model_reset();
    test_reset();
    test_single();
    test_priority();
    test_overflow();
    test_glb_en();
    test_ack_set();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
